// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_assoc #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    read,
  input  logic                                    write,
  input  logic [ADDR_W-1:0]                       address,
  input  logic [DATA_W-1:0]                       writedata,
  output logic [DATA_W-1:0]                       readdata,
  output logic                                    busywait,
  output logic                                    mem_read,
  output logic                                    mem_write,
  output logic [ADDR_W-$clog2(WORDS)-1:0]         mem_address,
  output logic [DATA_W*WORDS-1:0]                 mem_writedata,
  input  logic [DATA_W*WORDS-1:0]                 mem_readdata,
  input  logic                                    mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                             hit_count,
  output logic [31:0]                             miss_count
`endif
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W   = DATA_W * WORDS;
  localparam int MADDR_W = ADDR_W - OFF_W;
  localparam int AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W   = AGE_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

  state_t state, next_state;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  assign {tag, idx, off} = address;

  logic [BLK_W-1:0] data_mem  [WAYS][SETS];
  logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
  logic             valid_mem [WAYS][SETS];
  logic             dirty_mem [WAYS][SETS];
  logic [AGE_W-1:0] age_mem   [WAYS][SETS];

  logic             req;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_s;
  logic [WAY_W-1:0] victim_r;
  logic [BLK_W-1:0] hit_blk;
  logic [BLK_W-1:0] fill_blk_r;

  assign req = read | write;

  // Tag lookup; descending scan leaves the lowest-numbered matching way
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[w][idx] && (tag_mem[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end else begin
        hit     = hit;
      end
    end
  end

  // Victim choice: oldest way, overridden by the lowest-numbered invalid way
  always_comb begin
    victim_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_mem[w][idx] == AGE_W'(WAYS - 1)) begin
        victim_s = WAY_W'(w);
      end else begin
        victim_s = victim_s;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[w][idx]) begin
        victim_s = WAY_W'(w);
      end else begin
        victim_s = victim_s;
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          if (valid_mem[victim_s][idx] && dirty_mem[victim_s][idx]) begin
            next_state = WRITEBACK;
          end else begin
            next_state = FETCH;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WRITEBACK: next_state = mem_busywait ? WRITEBACK : FETCH;
      FETCH:     next_state = mem_busywait ? FETCH : FILL;
      FILL:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode: CPU handshake and memory request lines
  always_comb begin
    hit_blk       = data_mem[hit_way][idx];
    busywait      = req & ~((state == IDLE) & hit);
    readdata      = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    if ((state == IDLE) && hit && read && !write) begin
      readdata = hit_blk[int'(off)*DATA_W +: DATA_W];
    end else begin
      readdata = '0;
    end
    case (state)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = MADDR_W'({tag_mem[victim_r][idx], idx});
        mem_writedata = data_mem[victim_r][idx];
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = MADDR_W'({tag, idx});
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Victim way is frozen when the miss leaves IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      victim_r <= '0;
    end else if ((state == IDLE) && req && !hit) begin
      victim_r <= victim_s;
    end else begin
      victim_r <= victim_r;
    end
  end

  // Metadata: tags, valid, dirty and LRU ages
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_mem[w][s]   <= '0;
          valid_mem[w][s] <= 1'b0;
          dirty_mem[w][s] <= 1'b0;
          age_mem[w][s]   <= AGE_W'(w);
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == hit_way) begin
                age_mem[w][idx] <= '0;
              end else if (age_mem[w][idx] < age_mem[hit_way][idx]) begin
                age_mem[w][idx] <= age_mem[w][idx] + AGE_W'(1);
              end
            end
            if (write) begin
              dirty_mem[hit_way][idx] <= 1'b1;
            end
          end
        end
        FILL: begin
          tag_mem[victim_r][idx]   <= tag;
          valid_mem[victim_r][idx] <= 1'b1;
          dirty_mem[victim_r][idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Data blocks and fetch buffer survive reset by design
  always_ff @(posedge clock) begin
    if ((state == IDLE) && write && hit) begin
      data_mem[hit_way][idx][int'(off)*DATA_W +: DATA_W] <= writedata;
    end else if (state == FILL) begin
      data_mem[victim_r][idx] <= fill_blk_r;
    end
    if ((state == FETCH) && !mem_busywait) begin
      fill_blk_r <= mem_readdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic missed_r;

  // Saturating counters; an access that missed is not counted again as a hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      missed_r   <= 1'b0;
    end else if ((state == IDLE) && req && !hit) begin
      missed_r <= 1'b1;
      if (miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end else if (req && !busywait) begin
      missed_r <= 1'b0;
      if (!missed_r && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc: directed vector table, reset-in-writeback
// sequence, and randomized accesses against a recency-list cache model.
module tb_dcache_assoc;

  logic        clock = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_assoc dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Block memory: reloads its initial image whenever reset is low
  logic [31:0] mem_model [64];
  int          mem_lat = 0;
  int          req_cnt = 0;
  assign mem_readdata = mem_model[mem_address];

  function automatic logic [31:0] init_word(int b);
    logic [7:0] base;
    base = 8'(b * 4);
    if (b == 5) return 32'h4433_2211;
    return {base + 8'd3, base + 8'd2, base + 8'd1, base} ^ 32'hC3C3_C3C3;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      for (int b = 0; b < 64; b++) mem_model[b] = init_word(b);
      req_cnt      = 0;
      mem_busywait = 1'b0;
    end else if (mem_read || mem_write) begin
      if (req_cnt < mem_lat) begin
        mem_busywait = 1'b1;
      end else begin
        mem_busywait = 1'b0;
        if (mem_write) mem_model[mem_address] = mem_writedata;
      end
      req_cnt++;
    end else begin
      req_cnt      = 0;
      mem_busywait = 1'b0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One CPU access; starts just after a posedge, returns just after the completing posedge
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rdv, output int stalls,
                        output logic wb, output logic [5:0] wba, output logic [31:0] wbd,
                        output logic fe, output logic [5:0] fea);
    bit done = 0;
    read = rd; write = wr; address = a; writedata = wd;
    stalls = 0; wb = 0; wba = '0; wbd = '0; fe = 0; fea = '0; rdv = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (mem_read && mem_write) chk("mem_read_and_mem_write", 32'd1, 32'd0);
      if (mem_write) begin wb = 1; wba = mem_address; wbd = mem_writedata; end
      if (mem_read)  begin fe = 1; fea = mem_address; end
      if (!busywait) begin rdv = readdata; done = 1; break; end
      stalls++;
    end
    if (!done) chk("access_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  typedef struct {
    logic       rd, wr;
    logic [7:0] addr, wd;
    int         lat;
    logic       chk_rd;
    logic [7:0] exp_rd;
    int         exp_stall;
    logic       exp_wb;
    logic [5:0] exp_wba;
    logic [7:0] exp_wbb0;
    logic       exp_fe;
    logic [5:0] exp_fea;
  } vec_t;

  vec_t tbl [10];

  // Recency-list reference: front of each queue is the most recently used tag
  logic [3:0] rq [4][$];
  bit         dm [4][16];
  logic [7:0] ref_mem [256];

  initial begin
    logic [7:0]  rdv;
    logic [5:0]  wba, fea;
    logic [31:0] wbd;
    logic        wb, fe;
    int          stalls;
    bit          seen;

    tbl[0] = '{1'b1, 1'b0, 8'h14, 8'h00, 0, 1'b1, 8'h11, 3, 1'b0, 6'h00, 8'h00, 1'b1, 6'h05};
    tbl[1] = '{1'b1, 1'b0, 8'h15, 8'h00, 0, 1'b1, 8'h22, 0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00};
    tbl[2] = '{1'b0, 1'b1, 8'h14, 8'hAA, 0, 1'b0, 8'h00, 0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00};
    tbl[3] = '{1'b1, 1'b0, 8'h14, 8'h00, 0, 1'b1, 8'hAA, 0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00};
    tbl[4] = '{1'b1, 1'b0, 8'h34, 8'h00, 0, 1'b0, 8'h00, 3, 1'b0, 6'h00, 8'h00, 1'b1, 6'h0D};
    tbl[5] = '{1'b1, 1'b0, 8'h14, 8'h00, 0, 1'b1, 8'hAA, 0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00};
    tbl[6] = '{1'b1, 1'b0, 8'h54, 8'h00, 0, 1'b0, 8'h00, 3, 1'b0, 6'h00, 8'h00, 1'b1, 6'h15};
    tbl[7] = '{1'b0, 1'b1, 8'h54, 8'hBB, 0, 1'b0, 8'h00, 0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00};
    tbl[8] = '{1'b1, 1'b0, 8'h14, 8'h00, 0, 1'b1, 8'hAA, 0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00};
    tbl[9] = '{1'b1, 1'b0, 8'h74, 8'h00, 3, 1'b0, 8'h00, 7, 1'b1, 6'h15, 8'hBB, 1'b1, 6'h1D};

    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busywait", 32'(busywait), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_readdata", 32'(readdata), 32'd0);
    chk("reset_mem_address", 32'(mem_address), 32'd0);
    chk("reset_mem_writedata", mem_writedata, 32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 10; i++) begin
      mem_lat = tbl[i].lat;
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, rdv, stalls, wb, wba, wbd, fe, fea);
      chk($sformatf("vec%0d_stalls", i), 32'(stalls), 32'(tbl[i].exp_stall));
      chk($sformatf("vec%0d_mem_write_seen", i), 32'(wb), 32'(tbl[i].exp_wb));
      chk($sformatf("vec%0d_mem_read_seen", i), 32'(fe), 32'(tbl[i].exp_fe));
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_readdata", i), 32'(rdv), 32'(tbl[i].exp_rd));
      if (tbl[i].exp_wb) begin
        chk($sformatf("vec%0d_wb_address", i), 32'(wba), 32'(tbl[i].exp_wba));
        chk($sformatf("vec%0d_wb_data_byte0", i), 32'(wbd[7:0]), 32'(tbl[i].exp_wbb0));
      end
      if (tbl[i].exp_fe) chk($sformatf("vec%0d_fetch_address", i), 32'(fea), 32'(tbl[i].exp_fea));
    end
`ifdef DCACHE_STATS_EN
    chk("stats_miss_count", miss_count, 32'd4);
    chk("stats_hit_count", hit_count, 32'd6);
`endif

    // Reset pulled while a dirty victim is being written back
    mem_lat = 10;
    read = 1'b1; address = 8'h94;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_write) begin seen = 1; break; end
    end
    chk("midwb_reached_writeback", 32'(seen), 32'd1);
    #1;
    reset = 1'b0; read = 1'b0;
    #1;
    chk("midwb_mem_write", 32'(mem_write), 32'd0);
    chk("midwb_mem_read", 32'(mem_read), 32'd0);
    chk("midwb_busywait", 32'(busywait), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    mem_lat = 0;
    access(1'b1, 1'b0, 8'h14, 8'h00, rdv, stalls, wb, wba, wbd, fe, fea);
    chk("post_reset_miss", 32'(fe), 32'd1);
    chk("post_reset_fetch_address", 32'(fea), 32'h05);
    chk("post_reset_readdata", 32'(rdv), 32'h11);

    // Randomized phase from a clean reset
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    for (int b = 0; b < 64; b++)
      for (int k = 0; k < 4; k++) ref_mem[b*4 + k] = mem_model[b][k*8 +: 8];
    for (int s = 0; s < 4; s++) begin
      rq[s].delete();
      for (int t = 0; t < 16; t++) dm[s][t] = 0;
    end

    for (int n = 0; n < 250; n++) begin
      logic [3:0]  tg, vt;
      logic [1:0]  ix, of;
      logic [7:0]  a, wd;
      logic        rd, wr, is_hit, e_wb;
      logic [5:0]  e_wba;
      logic [31:0] e_wbd;
      int          op, lat, pos, e_st;
      tg  = 4'($urandom_range(0, 5));
      ix  = 2'($urandom_range(0, 3));
      of  = 2'($urandom_range(0, 3));
      a   = {tg, ix, of};
      wd  = 8'($urandom);
      op  = $urandom_range(0, 2);
      lat = $urandom_range(0, 2);
      rd  = (op != 1);
      wr  = (op != 0);
      pos = -1;
      foreach (rq[ix][q]) if (rq[ix][q] == tg) pos = q;
      is_hit = (pos >= 0);
      e_wb = 0; e_wba = '0; e_wbd = '0;
      if (is_hit) begin
        rq[ix].delete(pos);
      end else if (rq[ix].size() == 2) begin
        vt    = rq[ix].pop_back();
        e_wb  = dm[ix][vt];
        e_wba = {vt, ix};
        for (int k = 0; k < 4; k++) e_wbd[k*8 +: 8] = ref_mem[{vt, ix, 2'(k)}];
        dm[ix][vt] = 0;
      end
      rq[ix].push_front(tg);
      e_st = is_hit ? 0 : (3 + lat + (e_wb ? 1 : 0));

      mem_lat = lat;
      access(rd, wr, a, wd, rdv, stalls, wb, wba, wbd, fe, fea);
      chk($sformatf("rnd%0d_stalls", n), 32'(stalls), 32'(e_st));
      chk($sformatf("rnd%0d_mem_write_seen", n), 32'(wb), 32'(e_wb));
      chk($sformatf("rnd%0d_mem_read_seen", n), 32'(fe), 32'(!is_hit));
      if (e_wb) begin
        chk($sformatf("rnd%0d_wb_address", n), 32'(wba), 32'(e_wba));
        chk($sformatf("rnd%0d_wb_data", n), wbd, e_wbd);
      end
      if (!is_hit) chk($sformatf("rnd%0d_fetch_address", n), 32'(fea), 32'({tg, ix}));
      if (wr) begin
        ref_mem[a] = wd;
        dm[ix][tg] = 1;
      end else begin
        chk($sformatf("rnd%0d_readdata", n), 32'(rdv), 32'(ref_mem[a]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Successor to the direct-mapped 8-block data cache, and a drop-in between the CPU load/store path and the block-wide data memory.
- Keeps the same CPU and memory handshake: read/write/busywait toward the CPU, mem_read/mem_write/mem_busywait toward memory.

Parameters:
- ADDR_W, 8: CPU byte-address width.
- DATA_W, 8: CPU word width.
- WORDS, 4: words per block; power of 2; OFF_W = log2(WORDS).
- SETS, 4: number of sets; power of 2; IDX_W = log2(SETS).
- WAYS, 2: associativity; power of 2, 1..8.
- Derived widths: TAG_W = ADDR_W - IDX_W - OFF_W; BLK_W = DATA_W*WORDS; MADDR_W = ADDR_W - OFF_W.

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- read  in  1  CPU load request; held until busywait low
- write  in  1  CPU store request; held until busywait low
- address  in  ADDR_W  CPU address; split as {tag, index, offset}
- writedata  in  DATA_W  store data
- readdata  out  DATA_W  load data
- busywait  out  1  stall to CPU
- mem_read  out  1  block fetch request
- mem_write  out  1  block write-back request
- mem_address  out  MADDR_W  block address, {tag, index}
- mem_writedata  out  BLK_W  victim block
- mem_readdata  in  BLK_W  fetched block
- mem_busywait  in  1  memory busy

Behaviour:
- Per-way, per-set storage: data block, tag, valid, dirty, and an LRU age of log2(WAYS) bits (0 = most recent).
- Reset (reset low, asynchronous):
  - state = IDLE; all valid, dirty and age bits cleared, with ages initialised to way number.
  - busywait = 0, mem_read = 0, mem_write = 0, readdata = 0.
  - Data arrays are not cleared.
  - Reset mid-operation drops any memory request at once; dirty data is discarded.
- Lookup is combinational: hit = any way with valid set and tag match; hit_way is the lowest-numbered match.
- busywait = (read|write) & ~(state==IDLE & hit). It is combinational, so a hit completes in the request cycle with zero wait.
- read and write both high is treated as a write.
- Read hit: readdata = hit block word[offset], same cycle. LRU update at posedge.
- Write hit: at posedge, word[offset] of hit_way = writedata and dirty = 1. LRU update.
- LRU update: the touched way's age becomes 0; ways younger than its old age increment by 1.
- Victim on miss, latched at the IDLE exit:
  - lowest-numbered invalid way if one exists;
  - otherwise the way with age WAYS-1.
- FSM:
  - IDLE: on a miss with a valid+dirty victim, go to WRITEBACK; on a miss otherwise, go to FETCH.
  - WRITEBACK: mem_write = 1, mem_address = {victim tag, index}, mem_writedata = victim block. Go to FETCH at the first posedge with mem_busywait = 0.
  - FETCH: mem_read = 1, mem_address = {tag, index}. Go to FILL at the first posedge with mem_busywait = 0; mem_readdata is captured at that edge.
  - FILL: victim way gets data = captured block, tag, valid = 1, dirty = 0. Go to IDLE.
  - The access then hits in IDLE; a write hit then sets dirty.
- mem_read and mem_write are decoded from the state register and are never both high.
- Outside WRITEBACK/FETCH: mem_address = 0, mem_writedata = 0.
- Minimum miss latency, clean victim, mem_busywait low on the first cycle: FETCH 1 + FILL 1, then the hit cycle.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds output ports hit_count [31:0] and miss_count [31:0], reset to 0, saturating at 0xFFFFFFFF.
  - miss_count increments at each IDLE→WRITEBACK/FETCH transition.
  - hit_count increments at a completing posedge (request high, busywait low) only if that access never missed; an internal flag is set on miss and cleared on completion.
- Undefined: no ports and no counter logic.

Test Plan (default parameters):
- Cold read miss, clean victim:
  - Stimulus: reset, then read 0x14 (tag 1, index 1, offset 0). Memory returns 0x44332211.
  - Response: busywait = 1; FETCH with mem_read = 1, mem_address = 0x05; no mem_write. Next cycle after FILL: readdata = 0x11, busywait = 0; miss_count = 1.
- Read hit:
  - Stimulus: read 0x15.
  - Response: same cycle busywait = 0, readdata = 0x22; mem_read stays 0; hit_count = 1.
- Write hit:
  - Stimulus: write 0xAA to 0x14, then read 0x14.
  - Response: write completes with 0 stall cycles; the read returns 0xAA; no memory traffic.
- LRU eviction, clean victim:
  - Stimulus: read 0x34 (fills way1), read 0x14, read 0x54.
  - Response: way1 (tag 3, clean) is evicted; FETCH only, mem_address = 0x15; mem_write never asserted.
- Dirty eviction:
  - Stimulus: write 0xBB to 0x54, read 0x14, read 0x74.
  - Response: WRITEBACK with mem_write = 1, mem_address = 0x15, mem_writedata[7:0] = 0xBB; mem_busywait held 3 cycles keeps WRITEBACK. Then FETCH with mem_address = 0x1D.
- Reset mid-WRITEBACK:
  - Stimulus: pull reset low during WRITEBACK.
  - Response: mem_write = 0 and busywait = 0 immediately. After release, read 0x14 misses (mem_read = 1).
